// File: rtl/punc_hs_control.sv
`default_nettype none
// ============================================================================
// Module   : punc_hs_control
// Purpose  : Multi-cycle control FSM for the PUnC LC3 core. It drives the
//            datapath strobes and talks to the memory wrapper through a
//            req/ready handshake with variable latency. It also evaluates
//            conditional branches from the NZP flags, traps illegal opcodes
//            and memory timeouts, and supports halt/resume.
// Optional : `define PUNC_INSTRET_EN adds the retired-instruction counter and
//            the instret output port.
// Ports    :
//   clk, rst          clock; asynchronous active-low reset
//   ir[15:0]          instruction register contents
//   nzp[2:0]          datapath condition flags {N,Z,P}
//   mem_ready         memory completes the current access this cycle
//   resume            leave HALT
//   pc_clr/inc/w_en   PC clear / increment / load from ALU
//   ir_w_en, mdr_w_en capture memory read data into IR / MDR
//   mem_req, mem_we   memory request and write qualifier
//   mem_addr_s[1:0]   address select: 0=PC, 1=ALU, 2=MDR
//   rf_w_en, rf_w_s   register-file write enable / source (0=ALU,1=MEM,2=PC)
//   rf_*_addr[2:0]    register-file write and read addresses
//   alu_s[3:0]        ALU operation
//   status_w_en       NZP update
//   halted, error     status outputs
//   instret[CNT_W-1:0] retired instruction count (optional feature only)
// Revision : 1.0 - initial release
// ============================================================================
module punc_hs_control #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  input  logic        resume,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_w_en,
  output logic        ir_w_en,
  output logic        mdr_w_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_addr_s,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_s,
  output logic [2:0]  rf_w_addr,
  output logic [2:0]  rf_r0_addr,
  output logic [2:0]  rf_r1_addr,
  output logic [3:0]  alu_s,
  output logic        status_w_en,
  output logic        halted,
  output logic        error
`ifdef PUNC_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_clr    = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_mem_a  = 3'd4;
  localparam logic [2:0] c_st_mem_b  = 3'd5;
  localparam logic [2:0] c_st_halt   = 3'd6;
  localparam logic [2:0] c_st_err    = 3'd7;

  localparam logic [3:0] c_op_br   = 4'b0000;
  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_ld   = 4'b0010;
  localparam logic [3:0] c_op_st   = 4'b0011;
  localparam logic [3:0] c_op_jsr  = 4'b0100;
  localparam logic [3:0] c_op_and  = 4'b0101;
  localparam logic [3:0] c_op_ldr  = 4'b0110;
  localparam logic [3:0] c_op_str  = 4'b0111;
  localparam logic [3:0] c_op_rti  = 4'b1000;
  localparam logic [3:0] c_op_not  = 4'b1001;
  localparam logic [3:0] c_op_ldi  = 4'b1010;
  localparam logic [3:0] c_op_sti  = 4'b1011;
  localparam logic [3:0] c_op_jmp  = 4'b1100;
  localparam logic [3:0] c_op_rsv  = 4'b1101;
  localparam logic [3:0] c_op_lea  = 4'b1110;
  localparam logic [3:0] c_op_trap = 4'b1111;

  localparam logic [3:0] c_alu_pass = 4'hD;

  // Timeout fires on the wait cycle that brings the counter to MEM_TIMEOUT.
  localparam bit             c_to_en   = (MEM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] c_to_last = TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  // Elaboration-time parameter sanity checks
  if (MEM_TIMEOUT < 0 || MEM_TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
    $error("punc_hs_control: MEM_TIMEOUT must be in [0, 2^TO_W)");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("punc_hs_control: CNT_W must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [TO_W-1:0] r_wait;
  logic            w_timeout;
  logic [3:0]      w_op;
  logic            w_unused_ir;

  assign w_op        = ir[15:12];
  assign w_unused_ir = ^ir[5:3];

  // --------------------------------------------------------------------------
  // Register-file addresses: pure functions of IR, valid in every state
  // --------------------------------------------------------------------------
  always_comb begin
    rf_r1_addr = ir[2:0];
    if (w_op == c_op_st || w_op == c_op_str || w_op == c_op_sti) begin
      rf_r0_addr = ir[11:9];
    end else begin
      rf_r0_addr = ir[8:6];
    end
    if (w_op == c_op_jsr) begin
      rf_w_addr = 3'd7;
    end else begin
      rf_w_addr = ir[11:9];
    end
  end

  // --------------------------------------------------------------------------
  // Memory wait counter. Cleared on every state change so each request gets
  // its own budget; mem_req is a Moore output, so it never depends on r_wait.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_wait <= '0;
    end else if (mem_req && !mem_ready) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // A completing mem_ready always wins over the timeout in the same cycle.
  assign w_timeout = c_to_en && mem_req && !mem_ready && (r_wait == c_to_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_clr;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_clr: w_next = c_st_fetch;
      c_st_fetch: begin
        if (mem_ready)      w_next = c_st_decode;
        else if (w_timeout) w_next = c_st_err;
      end
      c_st_decode: begin
        case (w_op)
          c_op_add, c_op_and, c_op_not, c_op_lea,
          c_op_br, c_op_jmp, c_op_jsr:           w_next = c_st_exec;
          c_op_ld, c_op_ldr, c_op_st, c_op_str,
          c_op_ldi, c_op_sti:                    w_next = c_st_mem_a;
          c_op_trap:                             w_next = c_st_halt;
          c_op_rti, c_op_rsv:                    w_next = c_st_err;
          default:                               w_next = c_st_err;
        endcase
      end
      c_st_exec: w_next = c_st_fetch;
      c_st_mem_a: begin
        if (mem_ready) begin
          if (w_op == c_op_ldi || w_op == c_op_sti) w_next = c_st_mem_b;
          else                                      w_next = c_st_fetch;
        end else if (w_timeout) begin
          w_next = c_st_err;
        end
      end
      c_st_mem_b: begin
        if (mem_ready)      w_next = c_st_fetch;
        else if (w_timeout) w_next = c_st_err;
      end
      c_st_halt: begin
        if (resume) w_next = c_st_fetch;
      end
      c_st_err: w_next = c_st_err;
      default:  w_next = c_st_clr;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (Moore, some strobes qualified by mem_ready)
  // --------------------------------------------------------------------------
  always_comb begin
    pc_clr      = 1'b0;
    pc_inc      = 1'b0;
    pc_w_en     = 1'b0;
    ir_w_en     = 1'b0;
    mdr_w_en    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr_s  = 2'd0;
    rf_w_en     = 1'b0;
    rf_w_s      = 2'd0;
    alu_s       = 4'd0;
    status_w_en = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;
    case (r_state)
      c_st_clr: pc_clr = 1'b1;
      c_st_fetch: begin
        mem_req    = 1'b1;
        mem_addr_s = 2'd0;
        ir_w_en    = mem_ready;
      end
      c_st_decode: pc_inc = 1'b1;
      c_st_exec: begin
        alu_s = w_op;
        case (w_op)
          c_op_add, c_op_and, c_op_not, c_op_lea: begin
            rf_w_en     = 1'b1;
            rf_w_s      = 2'd0;
            status_w_en = 1'b1;
          end
          // BR with no condition bits set never loads the PC: a NOP.
          c_op_br:  pc_w_en = |(ir[11:9] & nzp);
          c_op_jmp: pc_w_en = 1'b1;
          // R7 gets the old PC while the PC loads the target in one cycle.
          c_op_jsr: begin
            rf_w_en = 1'b1;
            rf_w_s  = 2'd2;
            pc_w_en = 1'b1;
          end
          default: ;
        endcase
      end
      c_st_mem_a: begin
        mem_req    = 1'b1;
        mem_addr_s = 2'd1;
        alu_s      = w_op;
        case (w_op)
          c_op_st, c_op_str: mem_we = 1'b1;
          c_op_ld, c_op_ldr: begin
            rf_w_en     = mem_ready;
            rf_w_s      = 2'd1;
            status_w_en = mem_ready;
          end
          c_op_ldi, c_op_sti: mdr_w_en = mem_ready;
          default: ;
        endcase
      end
      c_st_mem_b: begin
        mem_req    = 1'b1;
        mem_addr_s = 2'd2;
        alu_s      = c_alu_pass;
        if (w_op == c_op_sti) begin
          mem_we = 1'b1;
        end
        if (w_op == c_op_ldi) begin
          rf_w_en     = mem_ready;
          rf_w_s      = 2'd1;
          status_w_en = mem_ready;
        end
      end
      c_st_halt: halted = 1'b1;
      c_st_err:  error  = 1'b1;
      default: ;
    endcase
  end

`ifdef PUNC_INSTRET_EN
  // --------------------------------------------------------------------------
  // Retired-instruction counter: bumps in the last cycle of each instruction.
  // A TRAP retires in DECODE; illegal opcodes never retire.
  // --------------------------------------------------------------------------
  logic             w_retire;
  logic [CNT_W-1:0] r_instret;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      c_st_exec:   w_retire = 1'b1;
      c_st_decode: w_retire = (w_op == c_op_trap);
      c_st_mem_a:  w_retire = mem_ready && (w_op != c_op_ldi) && (w_op != c_op_sti);
      c_st_mem_b:  w_retire = mem_ready;
      default:     w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_punc_hs_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_punc_hs_control
// Purpose  : Directed self-checking bench for punc_hs_control (MEM_TIMEOUT=4).
//            Covers reset, ADD, taken/not-taken branch, LDI with stalls,
//            HALT/resume, reset during an STI access, memory timeout and an
//            illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_punc_hs_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_ready;
  logic        resume;
  logic        pc_clr, pc_inc, pc_w_en, ir_w_en, mdr_w_en;
  logic        mem_req, mem_we;
  logic [1:0]  mem_addr_s;
  logic        rf_w_en;
  logic [1:0]  rf_w_s;
  logic [2:0]  rf_w_addr, rf_r0_addr, rf_r1_addr;
  logic [3:0]  alu_s;
  logic        status_w_en, halted, error;
`ifdef PUNC_INSTRET_EN
  logic [31:0] instret;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  punc_hs_control #(
    .MEM_TIMEOUT (4),
    .TO_W        (8),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ir          (ir),
    .nzp         (nzp),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .pc_clr      (pc_clr),
    .pc_inc      (pc_inc),
    .pc_w_en     (pc_w_en),
    .ir_w_en     (ir_w_en),
    .mdr_w_en    (mdr_w_en),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_s  (mem_addr_s),
    .rf_w_en     (rf_w_en),
    .rf_w_s      (rf_w_s),
    .rf_w_addr   (rf_w_addr),
    .rf_r0_addr  (rf_r0_addr),
    .rf_r1_addr  (rf_r1_addr),
    .alu_s       (alu_s),
    .status_w_en (status_w_en),
    .halted      (halted),
    .error       (error)
`ifdef PUNC_INSTRET_EN
    ,
    .instret     (instret)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_instret(input string tag, input logic [31:0] exp);
`ifdef PUNC_INSTRET_EN
    chk(tag, instret, exp);
`else
    if (exp == 32'hFFFF_FFFF) $error("FAIL %s: unreachable", tag);
`endif
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called while in FETCH: memory answers immediately with instruction v.
  // Returns settled in DECODE.
  task automatic fetch(input logic [15:0] v);
    ir        = v;
    mem_ready = 1'b1;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_ir_w_en", ir_w_en, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("decode_pc_inc", pc_inc, 1);
  endtask

  initial begin
    rst       = 1'b0;
    ir        = 16'h0000;
    nzp       = 3'b000;
    mem_ready = 1'b0;
    resume    = 1'b0;
    repeat (2) cyc();

    // ---------------- Reset state ----------------
    chk("rst_pc_clr", pc_clr, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_rf_w_en", rf_w_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk_instret("rst_instret", 0);

    // ---------------- ADD R1,R2,R3 ----------------
    rst = 1'b1;
    #1;
    chk("clr_pc_clr", pc_clr, 1);
    cyc();                                  // FETCH
    chk("fetch_pc_clr", pc_clr, 0);
    chk("fetch_addr_s", mem_addr_s, 0);
    fetch(16'h1283);                        // now DECODE
    chk("decode_mem_req", mem_req, 0);
    cyc();                                  // EXEC
    chk("add_rf_w_en", rf_w_en, 1);
    chk("add_rf_w_addr", rf_w_addr, 1);
    chk("add_status", status_w_en, 1);
    chk("add_rf_w_s", rf_w_s, 0);
    chk("add_alu_s", alu_s, 1);
    chk("add_r0", rf_r0_addr, 2);
    chk("add_r1", rf_r1_addr, 3);
    chk("add_pc_w_en", pc_w_en, 0);
    cyc();                                  // FETCH, 4 cycles after release
    chk("add_back_fetch", mem_req, 1);
    chk("add_back_addr", mem_addr_s, 0);
    chk_instret("add_instret", 1);

    // ---------------- BRnp not taken / taken ----------------
    nzp = 3'b010;
    fetch(16'h0A05);
    cyc();                                  // EXEC
    chk("br_nt_pc_w_en", pc_w_en, 0);
    chk("br_nt_rf_w_en", rf_w_en, 0);
    cyc();
    nzp = 3'b100;
    fetch(16'h0A05);
    cyc();
    chk("br_t_pc_w_en", pc_w_en, 1);
    cyc();
    chk_instret("br_instret", 3);

    // ---------------- LDI R2 with 3-cycle stalls ----------------
    fetch(16'hA402);
    cyc();                                  // MEM_A
    for (int i = 0; i < 3; i++) begin
      chk("ldi_a_req", mem_req, 1);
      chk("ldi_a_addr", mem_addr_s, 1);
      chk("ldi_a_mdr", mdr_w_en, 0);
      chk("ldi_a_rf", rf_w_en, 0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ldi_a_mdr_pulse", mdr_w_en, 1);
    chk("ldi_a_rf_ready", rf_w_en, 0);
    chk("ldi_a_alu", alu_s, 4'hA);
    cyc();                                  // MEM_B
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ldi_b_req", mem_req, 1);
      chk("ldi_b_addr", mem_addr_s, 2);
      chk("ldi_b_mdr", mdr_w_en, 0);
      chk("ldi_b_rf", rf_w_en, 0);
      chk("ldi_b_status", status_w_en, 0);
      chk("ldi_b_alu", alu_s, 4'hD);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ldi_b_rf_pulse", rf_w_en, 1);
    chk("ldi_b_status_pulse", status_w_en, 1);
    chk("ldi_b_rf_w_s", rf_w_s, 1);
    chk("ldi_b_we", mem_we, 0);
    chk("ldi_w_addr", rf_w_addr, 2);
    cyc();                                  // FETCH
    mem_ready = 1'b0;
    #1;
    chk("ldi_end_rf", rf_w_en, 0);
    chk("ldi_end_fetch", mem_req, 1);
    chk_instret("ldi_instret", 4);

    // ---------------- HALT / resume ----------------
    resume = 1'b1;                          // ignored outside HALT
    fetch(16'hF025);
    resume = 1'b0;
    chk("trap_halted_dec", halted, 0);
    cyc();                                  // HALT
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", halted, 1);
      chk("halt_req", mem_req, 0);
      cyc();
    end
    chk_instret("halt_instret", 5);
    resume = 1'b1;
    cyc();                                  // FETCH
    resume = 1'b0;
    #1;
    chk("resume_halted", halted, 0);
    chk("resume_fetch", mem_req, 1);

    // ---------------- Reset in the middle of an STI ----------------
    fetch(16'hB601);
    cyc();                                  // MEM_A
    chk("sti_a_we", mem_we, 0);
    chk("sti_r0", rf_r0_addr, 3);
    mem_ready = 1'b1;
    #1;
    chk("sti_a_mdr", mdr_w_en, 1);
    cyc();                                  // MEM_B
    mem_ready = 1'b0;
    #1;
    chk("sti_b_we", mem_we, 1);
    chk("sti_b_req", mem_req, 1);
    chk("sti_b_addr", mem_addr_s, 2);
    cyc();                                  // still stalled in MEM_B
    chk("sti_b_we_hold", mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_pc_clr", pc_clr, 1);
    chk_instret("rstmid_instret", 0);
    rst = 1'b1;

    // ---------------- Memory timeout in FETCH ----------------
    cyc();                                  // FETCH
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_err", error, 0);
      cyc();
    end
    chk("to_error", error, 1);
    chk("to_req_drop", mem_req, 0);
    resume = 1'b1;
    cyc();
    cyc();
    chk("to_sticky_err", error, 1);
    chk("to_no_halt", halted, 0);
    resume = 1'b0;
    rst = 1'b0;
    #1;
    chk("to_rst_err", error, 0);
    chk("to_rst_clr", pc_clr, 1);
    rst = 1'b1;

    // ---------------- Illegal opcode ----------------
    cyc();                                  // FETCH
    fetch(16'hD000);
    cyc();                                  // ERR
    chk("ill_error", error, 1);
    chk("ill_req", mem_req, 0);
    chk_instret("ill_instret", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
